onebit_core_param: RTL and testbench
====================================

# onebit_core_param

Parametrised second-generation 1-bit processor core. It replaces the fixed 2-input / 7-output / 16-word machine with configurable input, output, scratch-register and program-memory sizes. It adds XOR, scratch registers, single-step execution, a committed-word strobe and a visible program counter. Programs are loaded serially through `inReg[0]` while `en` is high, and the core executes when `en` is low.

## Interface
- `IN_REGS`, default 2: number of input bits.
- `OUT_REGS`, default 7: number of registered output bits.
- `SCR_REGS`, default 4: number of internal scratch bits.
- `PROG_DEPTH`, default 16: number of instruction words; must be a power of 2 and at most 2^AW.
- `AW`, default 5: operand field width. Requires IN_REGS+OUT_REGS+SCR_REGS ≤ 2^AW.
- `INSTR_W`, derived as 3+2*AW (13 at default): instruction width.
- `PW`, derived as clog2(PROG_DEPTH): PC width.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `en` input, 1 bit: 1 = load mode, 0 = execute mode.
- `inReg` input, IN_REGS bits: input bits. Bit 0 doubles as serial load data.
- `step_en` input, 1 bit: 1 = single-step mode.
- `step` input, 1 bit: in single-step mode, execute one instruction on each cycle this is high.
- `outReg` output, OUT_REGS bits: registered output bits.
- `pc` output, PW bits: current program counter.
- `instr_loaded` output, 1 bit: one-cycle pulse when a loaded word is written to memory.

## Operation
- Register address map, used for operand fields A and B:
  - 0..IN_REGS-1: inputs, read-only.
  - next OUT_REGS addresses: outReg bits.
  - next SCR_REGS addresses: scratch bits.
  - Addresses above the map read 0, and writes to them are dropped. Writes to input addresses are dropped.
- Instruction fields: [INSTR_W-1:INSTR_W-3] opcode, [2AW-1:AW] field A, [AW-1:0] field B.
- Opcodes (R[x] means the register at address x):
  - 000 NOP.
  - 001 MOV: R[B] ← R[A].
  - 010 NOT: R[B] ← ~R[A].
  - 011 AND: R[B] ← R[B] & R[A].
  - 100 OR: R[B] ← R[B] | R[A].
  - 101 XOR: R[B] ← R[B] ^ R[A].
  - 110 BZ: if R[A]==0, pc ← B[PW-1:0], otherwise pc+1.
  - 111 JMP: pc ← B[PW-1:0].
- Non-branch instructions advance pc to pc+1 mod PROG_DEPTH; pc wraps from PROG_DEPTH-1 to 0.
- Load mode (`en`=1):
  - Each cycle, `inReg[0]` shifts MSB-first into a load shift register, and a bit counter increments.
  - When the INSTR_W-th bit is shifted in, the full word is written to mem[load_ptr] on that edge. Then load_ptr increments (wrapping mod PROG_DEPTH), the bit counter clears, and `instr_loaded` pulses.
  - pc is held at 0. outReg and scratch bits hold their values.
- When `en` rises, load_ptr and the bit counter clear on that edge, so every load session starts at word 0.
- When `en` falls, a partial word is discarded and the bit counter clears. Execution starts at pc=0 on the first cycle with `en`=0.
- Execute mode (`en`=0):
  - With `step_en`=0, one instruction retires every cycle.
  - With `step_en`=1, an instruction retires only in cycles where `step`=1. Otherwise all state holds.
- Reset (asserted low, asynchronous) clears:
  - pc, outReg, scratch bits, load_ptr, bit counter and the shift register to 0;
  - `instr_loaded` to 0;
  - all memory words to 0 (NOP).

## Timing
- Instruction fetch and decode from mem[pc] are combinational. The write to the destination register and the pc update occur on the same rising edge, giving one instruction per cycle.
- Inputs are sampled in the retire cycle. No synchroniser is included inside the block.
- An outReg change is visible immediately after the retiring edge.
- Branches have no penalty. The instruction at the target executes in the next cycle.
- `instr_loaded` goes high for exactly the cycle after the committing edge.
- If `en` rises in the same cycle the INSTR_W-th bit would arrive, that word is not committed because the session restarts.
- Simultaneous `en`=1 and `step`: load mode wins, and step is ignored.
- Reset assertion mid-load or mid-execution takes effect immediately and asynchronously. After reset deasserts, the first active edge behaves as if from power-up.

## Test plan
- Reset defaults: assert `reset`=0 mid-run.
  - Required: outReg=0 and pc=0 immediately.
  - Required: after release with `en`=0, the core executes NOPs and pc counts 0,1,…,15,0.
- Serial load: with `en`=1, shift 13 ones, then 13 zeros.
  - Required: `instr_loaded` pulses twice, 13 cycles apart.
  - Required: mem[0]=0x1FFF and mem[1]=0x0000.
  - Required: a 5-bit partial word followed by `en` low leaves mem[2] at 0.
- Pass-through program: load 001_00000_00010 (MOV out0←in0), then 111_00000_00000 (JMP 0).
  - Required: toggling `inReg[0]` appears on `outReg[0]` within 2 cycles, and pc alternates 0,1.
- Conditional wait: load BZ in1→0 at word 0 (110_00001_00000), then MOV out1←in0 and JMP 0.
  - Required: with in1=0, pc stays at 0 and outReg stays 0.
  - Required: with in1=1, pc runs 0,1,2,0 and out1 follows in0.
- Single-step: pass-through program with `step_en`=1 and in0=1.
  - Required: pc holds for 10 idle cycles.
  - Required: one `step` pulse moves pc 0→1 and sets out0=1.
  - Required: a second pulse moves pc 1→0.
- XOR/scratch and wrap: load XOR scr0(addr 9)←in0, then MOV out2(addr 4)←scr0, padded with NOPs to 16 words.
  - Required: with in0=1, out2 toggles once per 16-cycle pass and pc wraps 15→0.

Source files
------------

// File: rtl/onebit_core_param.sv
// Parametrised 1-bit processor core with serial program load, scratch bits and single-step.
// Latency: one instruction retires per enabled cycle; fetch/decode is combinational from mem[pc].
// Backpressure: none; step_en/step gate retirement, and en=1 holds the core in load mode.
module onebit_core_param #(
    parameter int IN_REGS    = 2,
    parameter int OUT_REGS   = 7,
    parameter int SCR_REGS   = 4,
    parameter int PROG_DEPTH = 16,
    parameter int AW         = 5,
    localparam int INSTR_W   = 3 + 2 * AW,
    localparam int PW        = $clog2(PROG_DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [IN_REGS-1:0]  inReg,
    input  logic                step_en,
    input  logic                step,
    output logic [OUT_REGS-1:0] outReg,
    output logic [PW-1:0]       pc,
    output logic                instr_loaded
);

    localparam int CW = $clog2(INSTR_W);

    logic [INSTR_W-1:0]  mem_q [PROG_DEPTH];
    logic [INSTR_W-2:0]  shift_q, shift_d;
    logic [CW-1:0]       bitcnt_q, bitcnt_d;
    logic [PW-1:0]       ld_ptr_q, ld_ptr_d;
    logic [PW-1:0]       pc_q, pc_d;
    logic [OUT_REGS-1:0] out_q, out_d;
    logic [SCR_REGS-1:0] scr_q, scr_d;
    logic                ld_pulse_q, ld_pulse_d;

    logic [INSTR_W-1:0]  instr;
    logic [INSTR_W-1:0]  ld_word;
    logic [2:0]          op;
    logic [AW-1:0]       fa, fb;
    logic                ra, rb, wval, wr_en, retire, commit;

    assign instr   = mem_q[pc_q];
    assign op      = instr[INSTR_W-1 -: 3];
    assign fa      = instr[2*AW-1 -: AW];
    assign fb      = instr[AW-1:0];
    assign retire  = ~en & (~step_en | step);
    assign commit  = en && (bitcnt_q == CW'(INSTR_W - 1));
    assign ld_word = {shift_q, inReg[0]};

    // Register file read: inputs, then outputs, then scratch; unmapped addresses read 0.
    always_comb begin
        ra = 1'b0;
        rb = 1'b0;
        for (int i = 0; i < IN_REGS; i++) begin
            if (int'(fa) == i) ra = inReg[i];
            if (int'(fb) == i) rb = inReg[i];
        end
        for (int i = 0; i < OUT_REGS; i++) begin
            if (int'(fa) == IN_REGS + i) ra = out_q[i];
            if (int'(fb) == IN_REGS + i) rb = out_q[i];
        end
        for (int i = 0; i < SCR_REGS; i++) begin
            if (int'(fa) == IN_REGS + OUT_REGS + i) ra = scr_q[i];
            if (int'(fb) == IN_REGS + OUT_REGS + i) rb = scr_q[i];
        end
    end

    always_comb begin
        wval  = 1'b0;
        wr_en = 1'b0;
        case (op)
            3'b001:  begin wval = ra;      wr_en = 1'b1; end
            3'b010:  begin wval = ~ra;     wr_en = 1'b1; end
            3'b011:  begin wval = rb & ra; wr_en = 1'b1; end
            3'b100:  begin wval = rb | ra; wr_en = 1'b1; end
            3'b101:  begin wval = rb ^ ra; wr_en = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        pc_d  = pc_q;
        out_d = out_q;
        scr_d = scr_q;
        if (en) begin
            pc_d = '0;
        end else if (retire) begin
            case (op)
                3'b110:  pc_d = ra ? pc_q + PW'(1) : fb[PW-1:0];
                3'b111:  pc_d = fb[PW-1:0];
                default: pc_d = pc_q + PW'(1);
            endcase
            // Input and unmapped destinations simply match no bit below.
            if (wr_en) begin
                for (int i = 0; i < OUT_REGS; i++)
                    if (int'(fb) == IN_REGS + i) out_d[i] = wval;
                for (int i = 0; i < SCR_REGS; i++)
                    if (int'(fb) == IN_REGS + OUT_REGS + i) scr_d[i] = wval;
            end
        end
    end

    // Counter and pointer sit at 0 outside load mode, so each session starts at word 0.
    always_comb begin
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        ld_ptr_d   = ld_ptr_q;
        ld_pulse_d = 1'b0;
        if (!en) begin
            bitcnt_d = '0;
            ld_ptr_d = '0;
        end else begin
            shift_d = {shift_q[INSTR_W-3:0], inReg[0]};
            if (commit) begin
                bitcnt_d   = '0;
                ld_ptr_d   = ld_ptr_q + PW'(1);
                ld_pulse_d = 1'b1;
            end else begin
                bitcnt_d = bitcnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PROG_DEPTH; i++) mem_q[i] <= '0;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            ld_ptr_q   <= '0;
            pc_q       <= '0;
            out_q      <= '0;
            scr_q      <= '0;
            ld_pulse_q <= 1'b0;
        end else begin
            if (commit) mem_q[ld_ptr_q] <= ld_word;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            ld_ptr_q   <= ld_ptr_d;
            pc_q       <= pc_d;
            out_q      <= out_d;
            scr_q      <= scr_d;
            ld_pulse_q <= ld_pulse_d;
        end
    end

    assign outReg       = out_q;
    assign pc           = pc_q;
    assign instr_loaded = ld_pulse_q;

endmodule

// File: tb/tb_onebit_core_param.sv
// Scoreboarded bench for onebit_core_param: stimulus queues expected pc/outReg and load pulses,
// a negedge monitor pops and compares them.
module tb_onebit_core_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [1:0] inReg = 2'b00;
    logic       step_en = 1'b0;
    logic       step = 1'b0;
    logic [6:0] outReg;
    logic [3:0] pc;
    logic       instr_loaded;

    int cyc_cnt = 0;
    int total = 0;
    int bad = 0;

    int         exp_tag [$];
    logic [3:0] exp_pc  [$];
    logic [6:0] exp_out [$];
    string      exp_nm  [$];
    int         ld_q    [$];

    logic [7:0] pt_in  = 8'b0011_0011;
    logic [7:0] pt_out = 8'b0011_0011;
    logic [5:0] cw_in  = 6'b000111;
    logic [5:0] cw_out = 6'b001110;
    logic [1:0] cw_pc [6] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};

    onebit_core_param dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .inReg        (inReg),
        .step_en      (step_en),
        .step         (step),
        .outReg       (outReg),
        .pc           (pc),
        .instr_loaded (instr_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin : monitor
        int         t;
        logic [3:0] p;
        logic [6:0] o;
        string      nm;
        logic       il_exp;
        while (exp_tag.size() > 0 && exp_tag[0] <= cyc_cnt) begin
            t  = exp_tag.pop_front();
            p  = exp_pc.pop_front();
            o  = exp_out.pop_front();
            nm = exp_nm.pop_front();
            total++;
            if (t != cyc_cnt) begin
                bad++;
                $display("FAIL %s stale: tag=%0d cycle=%0d", nm, t, cyc_cnt);
            end else if (pc !== p) begin
                bad++;
                $display("FAIL %s pc: got=%0d want=%0d (cycle %0d)", nm, pc, p, cyc_cnt);
            end
            total++;
            if (t == cyc_cnt && outReg !== o) begin
                bad++;
                $display("FAIL %s outReg: got=%b want=%b (cycle %0d)", nm, outReg, o, cyc_cnt);
            end
        end
        il_exp = (ld_q.size() > 0 && ld_q[0] == cyc_cnt);
        if (il_exp) void'(ld_q.pop_front());
        total++;
        if (instr_loaded !== il_exp) begin
            bad++;
            $display("FAIL instr_loaded: got=%b want=%b (cycle %0d)", instr_loaded, il_exp, cyc_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] p, input logic [6:0] o);
        exp_tag.push_back(cyc_cnt);
        exp_pc.push_back(p);
        exp_out.push_back(o);
        exp_nm.push_back(nm);
    endtask

    task automatic load_word(input logic [12:0] w, input logic [6:0] o);
        for (int i = 12; i >= 0; i--) begin
            en       = 1'b1;
            inReg[0] = w[i];
            tick();
            chk("load", 4'd0, o);
            if (i == 0) ld_q.push_back(cyc_cnt);
        end
    endtask

    initial begin
        // Power-up reset, then NOPs from cleared memory.
        tick(); chk("rst_hold", 4'd0, 7'h00);
        tick(); chk("rst_hold", 4'd0, 7'h00);
        reset = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick(); chk("nop_run", 4'(i % 16), 7'h00);
        end

        // Serial load of all-ones and all-zeros words, then a discarded partial word.
        load_word(13'h1FFF, 7'h00);
        load_word(13'h0000, 7'h00);
        inReg[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); chk("partial", 4'd0, 7'h00);
        end
        en = 1'b0;
        tick(); chk("jmp15", 4'd15, 7'h00);
        tick(); chk("wrap0", 4'd0, 7'h00);
        tick(); chk("jmp15", 4'd15, 7'h00);
        tick(); chk("wrap0", 4'd0, 7'h00);

        // Pass-through: MOV out0<-in0; JMP 0.
        load_word(13'h0402, 7'h00);
        load_word(13'h1C00, 7'h00);
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            inReg[0] = pt_in[i];
            tick(); chk("passthru", (i % 2 == 0) ? 4'd1 : 4'd0, {6'b0, pt_out[i]});
        end

        // Conditional wait: BZ in1->0; MOV out1<-in0; JMP 0.
        load_word(13'h1820, 7'h00);
        load_word(13'h0403, 7'h00);
        load_word(13'h1C00, 7'h00);
        en    = 1'b0;
        inReg = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick(); chk("bz_wait", 4'd0, 7'h00);
        end
        inReg[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            inReg[0] = cw_in[i];
            tick(); chk("bz_run", 4'(cw_pc[i]), {5'b0, cw_out[i], 1'b0});
        end

        // Single-step on the pass-through program.
        load_word(13'h0402, 7'h00);
        load_word(13'h1C00, 7'h00);
        en       = 1'b0;
        inReg    = 2'b01;
        step_en  = 1'b1;
        step     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(); chk("step_idle", 4'd0, 7'h00);
        end
        step = 1'b1; tick(); chk("step1", 4'd1, 7'h01);
        step = 1'b0; tick(); chk("step_hold", 4'd1, 7'h01);
        tick(); chk("step_hold", 4'd1, 7'h01);
        step = 1'b1; tick(); chk("step2", 4'd0, 7'h01);
        tick(); chk("step3", 4'd1, 7'h01);
        en = 1'b1; tick(); chk("load_wins", 4'd0, 7'h01);
        en = 1'b0; step = 1'b0; tick(); chk("step_hold2", 4'd0, 7'h01);
        step = 1'b1; tick(); chk("step4", 4'd1, 7'h01);
        step = 1'b0;
        step_en = 1'b0;

        // XOR into scratch, MOV scratch to out2, NOP padding to 16 words.
        load_word(13'h1409, 7'h01);
        load_word(13'h0524, 7'h01);
        for (int w = 0; w < 14; w++) load_word(13'h0000, 7'h01);
        en    = 1'b0;
        inReg = 2'b01;
        for (int t = 0; t < 40; t++) begin
            logic o2;
            o2 = (t == 0) ? 1'b0 : (((t - 1) / 16) % 2 == 0);
            tick(); chk("xor_wrap", 4'((t + 1) % 16), {4'b0, o2, 1'b0, 1'b1});
        end

        // Asynchronous reset mid-execution, then NOPs from cleared memory.
        tick();
        reset = 1'b0;
        #1;
        chk("rst_async", 4'd0, 7'h00);
        tick(); chk("rst_hold2", 4'd0, 7'h00);
        reset = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick(); chk("post_rst_nop", 4'(i % 16), 7'h00);
        end

        tick();
        tick();
        total++;
        if (exp_tag.size() != 0 || ld_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending_state=%0d pending_loads=%0d want 0", exp_tag.size(), ld_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
